// File: rtl/debounce_multi_pkg.sv
// Shared constants for the multi-channel debouncer: width helper, board defaults and
// the per-channel level encoding.
package debounce_multi_pkg;

   // 1250000 cycles at 100 MHz is about 12.5 ms between filter samples.
   localparam int unsigned DEFAULT_SAMPLE_PERIOD  = 1250000;
   localparam int unsigned DEFAULT_STABLE_SAMPLES = 4;

   typedef enum logic {
      LvlLow  = 1'b0,
      LvlHigh = 1'b1
   } level_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      longint unsigned pow;
      result = 0;
      pow    = 1;
      while (pow < longint'(value)) begin
         pow    = pow << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, sample history and a hysteresis level register
// with single-cycle rise/fall pulses.
module debounce_channel
   import debounce_multi_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic inp_bit,
   output logic out_bit,
   output logic rise_bit,
   output logic fall_bit
);

   logic [SYNC_STAGES-1:0]    sync_q;
   logic [STABLE_SAMPLES-1:0] hist_q;
   level_e                    level_q;
   logic                      rise_q;
   logic                      fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         hist_q  <= '0;
         level_q <= LvlLow;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], inp_bit};
         if (tick) begin
            hist_q <= {hist_q[STABLE_SAMPLES-2:0], sync_q[SYNC_STAGES-1]};
         end
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         // Only a unanimous history flips the level; mixed histories hold it.
         unique case (level_q)
            LvlLow: begin
               if (&hist_q) begin
                  level_q <= LvlHigh;
                  rise_q  <= 1'b1;
               end
            end
            LvlHigh: begin
               if (~|hist_q) begin
                  level_q <= LvlLow;
                  fall_q  <= 1'b1;
               end
            end
            default: level_q <= LvlLow;
         endcase
      end
   end

   assign out_bit  = (level_q == LvlHigh);
   assign rise_bit = rise_q;
   assign fall_bit = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: one shared sample-period prescaler driving CHANNELS
// independent debounce lanes.
module debounce_multi
   import debounce_multi_pkg::*;
#(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned SAMPLE_PERIOD  = DEFAULT_SAMPLE_PERIOD,
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] inp,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                sample_tick
);

   localparam int unsigned CNT_W = (clog2(SAMPLE_PERIOD) < 1) ? 1 : clog2(SAMPLE_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             tick;
   logic             tick_q;

   // Wrap on the terminal count so tick spacing is exactly SAMPLE_PERIOD.
   assign tick = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
         tick_q <= tick;
      end
   end

   assign sample_tick = tick_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .inp_bit  (inp[g]),
         .out_bit  (out[g]),
         .rise_bit (rise[g]),
         .fall_bit (fall[g])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: an edge-indexed reference model pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_debounce_multi;

   localparam int unsigned CH = 2;
   localparam int unsigned P  = 4;
   localparam int unsigned N  = 3;
   localparam int unsigned S  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [CH-1:0] inp;
   logic [CH-1:0] out, rise, fall;
   logic          sample_tick;

   debounce_multi #(
      .CHANNELS       (CH),
      .SAMPLE_PERIOD  (P),
      .STABLE_SAMPLES (N),
      .SYNC_STAGES    (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inp         (inp),
      .out         (out),
      .rise        (rise),
      .fall        (fall),
      .sample_tick (sample_tick)
   );

   logic rst6 = 1'b1;
   logic inp6 = 1'b0;
   logic out6, rise6, fall6, tick6;

   debounce_multi #(
      .CHANNELS       (1),
      .SAMPLE_PERIOD  (1),
      .STABLE_SAMPLES (2),
      .SYNC_STAGES    (2)
   ) dut6 (
      .clk         (clk),
      .rst         (rst6),
      .inp         (inp6),
      .out         (out6),
      .rise        (rise6),
      .fall        (fall6),
      .sample_tick (tick6)
   );

   typedef struct packed {
      logic [CH-1:0] out;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic          tick;
   } exp_t;

   exp_t expq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: edges since reset, inputs applied before each edge,
   // the last N filter samples and the debounced level.
   int unsigned   k;
   logic [CH-1:0] applied[$];
   logic [CH-1:0] samples[$];
   logic [CH-1:0] lvl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic [CH-1:0] v, output exp_t e);
      logic [CH-1:0] synced, all1, all0;
      e = '0;
      if (r) begin
         k = 0;
         applied.delete();
         applied.push_back('0);
         samples.delete();
         for (int i = 0; i < int'(N); i++) samples.push_back('0);
         lvl = '0;
      end else begin
         k++;
         applied.push_back(v);
         // Value leaving the synchroniser at edge k was applied S edges earlier.
         synced = (k > S) ? applied[k-S] : '0;
         all1 = '1;
         all0 = '1;
         foreach (samples[j]) begin
            all1 &= samples[j];
            all0 &= ~samples[j];
         end
         for (int c = 0; c < int'(CH); c++) begin
            if (all1[c] && !lvl[c]) begin
               lvl[c] = 1'b1;
               e.rise[c] = 1'b1;
            end else if (all0[c] && lvl[c]) begin
               lvl[c] = 1'b0;
               e.fall[c] = 1'b1;
            end
         end
         if (k % P == 0) begin
            samples.push_back(synced);
            void'(samples.pop_front());
            e.tick = 1'b1;
         end
      end
      e.out = lvl;
   endtask

   task automatic cyc(input logic r, input logic [CH-1:0] v);
      exp_t e;
      rst = r;
      inp = v;
      model_edge(r, v, e);
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [CH-1:0] v, input int n);
      repeat (n) cyc(1'b0, v);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check("out", 32'(out), 32'(e.out));
         check("rise", 32'(rise), 32'(e.rise));
         check("fall", 32'(fall), 32'(e.fall));
         check("sample_tick", 32'(sample_tick), 32'(e.tick));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0] cur, drv;
      logic          r;
      int            n;

      repeat (3) cyc(1'b1, '0);
      hold(2'b00, 20);

      // Single-channel steps landing on every prescaler phase.
      for (int ph = 0; ph < 4; ph++) begin
         hold(2'b00, ph + 1);
         hold(2'b01, 20);
         hold(2'b00, 20);
      end

      // Short glitch and alternating samples while high, then a real release.
      hold(2'b01, 20);
      hold(2'b00, 1);
      hold(2'b01, 20);
      for (int rep = 0; rep < 2; rep++) begin
         hold(2'b01, P);
         hold(2'b00, P);
      end
      hold(2'b01, 20);
      hold(2'b00, 20);

      hold(2'b11, 20);
      cyc(1'b1, 2'b11);
      hold(2'b11, 20);

      cur = 2'b11;
      for (int i = 0; i < 800; i++) begin
         r = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0) cur = cur ^ CH'($urandom_range(1, 3));
         drv = cur;
         if ($urandom_range(0, 15) == 0) drv = cur ^ CH'($urandom_range(1, 3));
         cyc(r, drv);
      end
      hold(cur, 20);
      @(negedge clk);
      #1;
      check("drain", 32'(expq.size()), 32'd0);

      // Fastest configuration: one sample per cycle, two-sample filter.
      rst6 = 1'b1;
      inp6 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("p1_rst_out", 32'(out6), 32'd0);
      check("p1_rst_tick", 32'(tick6), 32'd0);
      rst6 = 1'b0;
      inp6 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("p1_tick_high", 32'(tick6), 32'd1);
      end
      inp6 = 1'b1;
      n = 21;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out6) begin
            n = i;
            break;
         end
      end
      check("p1_rise_latency", 32'(n), 32'd5);
      check("p1_rise_pulse", 32'(rise6), 32'd1);
      @(posedge clk);
      #1;
      check("p1_rise_single", 32'(rise6), 32'd0);
      inp6 = 1'b0;
      n = 21;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (!out6) begin
            n = i;
            break;
         end
      end
      check("p1_fall_latency", 32'(n), 32'd5);
      check("p1_fall_pulse", 32'(fall6), 32'd1);
      @(posedge clk);
      #1;
      check("p1_fall_single", 32'(fall6), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
